vga_fb_arbiter: RTL

- Arbitrates a single-port frame-buffer RAM between two requesters: the VGA scan-out path (read, deadline-critical) and a pixel writer (drawing/SW-driven, best-effort).
- Generates the scan read addresses itself and buffers returned pixels in an internal prefetch FIFO.
- Sits between the frame-buffer RAM and the VGA timing/colour output logic on the CLOCK_50 domain.

---
 rtl/vga_fb_arbiter.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares one single-port frame-buffer RAM between the VGA scan-out
// path (deadline-critical reads) and a best-effort pixel writer.
//
// Scan reads are generated internally and land in a prefetch FIFO. Urgent scan reads
// (occupancy below half) beat the writer; the writer beats non-urgent scan reads.
// All RAM-side and consumer-side outputs are registered.
//
// Ports:
//   CLOCK_50, RESET_N          clock, asynchronous active-low reset
//   frame_start                pulse: flush FIFO, restart scan at address 0
//   pix_pop / pix_data /
//   pix_empty / underrun       prefetch FIFO consumer side (underrun is sticky)
//   wr_req / wr_addr / wr_data /
//   wr_ack / wr_err            writer handshake (req held until ack)
//   ram_addr / ram_we /
//   ram_wdata / ram_re /
//   ram_rdata                  frame-buffer RAM, read data RAM_LAT cycles after ram_re
//
// Optional feature (macro VGA_FB_ARB_STATS_EN): adds stall_cnt, a saturating count of
// cycles where the writer requests but is not acked; cleared by frame_start.
module vga_fb_arbiter #(
    parameter int unsigned ADDR_W     = 15,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FB_PIXELS  = 19200,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned RAM_LAT    = 2
) (
    input  logic              CLOCK_50,
    input  logic              RESET_N,
    input  logic              frame_start,
    input  logic              pix_pop,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_empty,
    output logic              underrun,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    output logic              wr_err,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_re,
    input  logic [DATA_W-1:0] ram_rdata
`ifdef VGA_FB_ARB_STATS_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned OCC_W = $clog2(FIFO_DEPTH + RAM_LAT + 2) + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_PIXELS - 1);
    localparam logic [OCC_W-1:0]  OCC_FULL  = OCC_W'(FIFO_DEPTH);
    localparam logic [OCC_W-1:0]  OCC_HALF  = OCC_W'(FIFO_DEPTH / 2);

    typedef enum logic [1:0] {StIdle, StFill, StDone} stateT;

    stateT               stateQ, stateD;
    logic [ADDR_W-1:0]   scanAddrQ, scanAddrD;
    // tagQ[k] marks a scan read whose ram_re was high k cycles ago
    logic [RAM_LAT:0]    tagQ, tagD;
    logic [DATA_W-1:0]   fifoMem [FIFO_DEPTH];
    logic [PTR_W-1:0]    rdPtrQ, rdPtrD, wrPtrQ, wrPtrD;
    logic [CNT_W-1:0]    countQ, countD;
    logic [DATA_W-1:0]   pixDataQ, pixDataD;
    logic                pixEmptyQ, pixEmptyD;
    logic                underrunQ, underrunD;
    logic [ADDR_W-1:0]   ramAddrQ, ramAddrD;
    logic [DATA_W-1:0]   ramWdataQ, ramWdataD;
    logic                ramWeQ, ramWeD, ramReQ, ramReD;
    logic                wrAckQ, wrAckD, wrErrQ, wrErrD;

    logic [OCC_W-1:0]    occ, occEff;
    logic [ADDR_W-1:0]   scanBase;
    logic                fillEff, eligible, urgent, wrWant, issueScan, grantWr, wrOob;
    logic                push, pop;

    // Occupancy counts reads still in flight, including one landing this cycle.
    always_comb begin
        occ = OCC_W'(countQ);
        for (int k = 0; k <= int'(RAM_LAT); k++) begin
            occ = occ + OCC_W'(tagQ[k]);
        end
    end

    always_comb begin
        // frame_start flushes everything, so decisions this cycle see an empty pipe
        fillEff  = frame_start || (stateQ == StFill);
        occEff   = frame_start ? '0 : occ;
        scanBase = frame_start ? '0 : scanAddrQ;
        eligible = fillEff && (occEff < OCC_FULL);
        urgent   = eligible && (occEff < OCC_HALF);
        // The cycle carrying an ack cannot grant again: wr_req is still the old request.
        wrWant    = wr_req && !wrAckQ;
        issueScan = urgent || (eligible && !wrWant);
        grantWr   = wrWant && !issueScan;
        wrOob     = wr_addr > LAST_ADDR;

        ramReD    = 1'b0;
        ramWeD    = 1'b0;
        ramAddrD  = '0;
        ramWdataD = '0;
        wrAckD    = 1'b0;
        wrErrD    = 1'b0;
        stateD    = stateQ;
        scanAddrD = scanAddrQ;

        if (frame_start) begin
            stateD    = StFill;
            scanAddrD = '0;
        end

        if (issueScan) begin
            ramReD    = 1'b1;
            ramAddrD  = scanBase;
            scanAddrD = scanBase + ADDR_W'(1);
            if (scanBase == LAST_ADDR) begin
                stateD = StDone;
            end
        end else if (grantWr) begin
            wrAckD = 1'b1;
            if (wrOob) begin
                wrErrD = 1'b1;
            end else begin
                ramWeD    = 1'b1;
                ramAddrD  = wr_addr;
                ramWdataD = wr_data;
            end
        end

        push = tagQ[RAM_LAT] && !frame_start;
        pop  = pix_pop && (countQ != '0) && !frame_start;

        if (frame_start) begin
            tagD   = {{RAM_LAT{1'b0}}, issueScan};
            rdPtrD = '0;
            wrPtrD = '0;
            countD = '0;
        end else begin
            tagD   = {tagQ[RAM_LAT-1:0], issueScan};
            rdPtrD = rdPtrQ + PTR_W'(pop);
            wrPtrD = wrPtrQ + PTR_W'(push);
            countD = countQ + CNT_W'(push) - CNT_W'(pop);
        end

        underrunD = frame_start ? 1'b0 : (underrunQ || (pix_pop && (countQ == '0)));
        pixEmptyD = (countD == '0);
        pixDataD  = pixDataQ;
        if (countD != '0) begin
            // New head may be the word being written this very cycle.
            pixDataD = (push && (wrPtrQ == rdPtrD)) ? ram_rdata : fifoMem[rdPtrD];
        end
    end

`ifdef VGA_FB_ARB_STATS_EN
    logic [15:0] stallCntQ, stallCntD;

    always_comb begin
        stallCntD = stallCntQ;
        if (frame_start) begin
            stallCntD = '0;
        end else if (wr_req && !wrAckQ && (stallCntQ != 16'hFFFF)) begin
            stallCntD = stallCntQ + 16'd1;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            stallCntQ <= '0;
        end else begin
            stallCntQ <= stallCntD;
        end
    end

    assign stall_cnt = stallCntQ;
`endif

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            stateQ    <= StIdle;
            scanAddrQ <= '0;
            tagQ      <= '0;
            rdPtrQ    <= '0;
            wrPtrQ    <= '0;
            countQ    <= '0;
            pixDataQ  <= '0;
            pixEmptyQ <= 1'b1;
            underrunQ <= 1'b0;
            ramAddrQ  <= '0;
            ramWdataQ <= '0;
            ramWeQ    <= 1'b0;
            ramReQ    <= 1'b0;
            wrAckQ    <= 1'b0;
            wrErrQ    <= 1'b0;
        end else begin
            stateQ    <= stateD;
            scanAddrQ <= scanAddrD;
            tagQ      <= tagD;
            rdPtrQ    <= rdPtrD;
            wrPtrQ    <= wrPtrD;
            countQ    <= countD;
            pixDataQ  <= pixDataD;
            pixEmptyQ <= pixEmptyD;
            underrunQ <= underrunD;
            ramAddrQ  <= ramAddrD;
            ramWdataQ <= ramWdataD;
            ramWeQ    <= ramWeD;
            ramReQ    <= ramReD;
            wrAckQ    <= wrAckD;
            wrErrQ    <= wrErrD;
        end
    end

    // Storage needs no reset: count/pointers define what is valid.
    always_ff @(posedge CLOCK_50) begin
        if (push) begin
            fifoMem[wrPtrQ] <= ram_rdata;
        end
    end

    assign pix_data  = pixDataQ;
    assign pix_empty = pixEmptyQ;
    assign underrun  = underrunQ;
    assign ram_addr  = ramAddrQ;
    assign ram_wdata = ramWdataQ;
    assign ram_we    = ramWeQ;
    assign ram_re    = ramReQ;
    assign wr_ack    = wrAckQ;
    assign wr_err    = wrErrQ;

endmodule
